// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : Direct-mapped BTB with 2-bit saturating counters for fetch-time
//            prediction, plus EX-stage branch resolution, table training,
//            a registered mispredict/redirect pulse and event counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  // fetch-side prediction
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  // execute-side resolution
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     resolved_count,
  output logic [31:0]     mispredict_count
);

  localparam int              c_IDX     = $clog2(ENTRIES);
  localparam int              c_TAG     = XLEN - c_IDX - 2;
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
  localparam logic [1:0]      c_CTR_RST = 2'b01;
  localparam logic [1:0]      c_CTR_MAX = 2'b11;
  localparam logic [1:0]      c_CTR_NEW = 2'b10;

  // BTB storage; only valid and counters carry a reset value
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [c_TAG-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic               r_mispredict;
  logic [XLEN-1:0]    r_redirect_pc;
  logic [31:0]        r_resolved;
  logic [31:0]        r_mispred_cnt;

  // fetch lookup
  logic [c_IDX-1:0]   w_if_idx;
  logic [c_TAG-1:0]   w_if_tag;
  // execute lookup
  logic [c_IDX-1:0]   w_ex_idx;
  logic [c_TAG-1:0]   w_ex_tag;
  logic               w_ex_hit;
  logic [1:0]         w_ex_ctr;
  // resolution
  logic               w_cond;
  logic               w_cond_known;
  logic               w_resolve;
  logic               w_tbl_wr;
  logic [1:0]         w_ctr_new;
  logic               w_mispred;
  logic [XLEN-1:0]    w_correct_pc;

  assign w_if_idx    = if_pc[c_IDX+1:2];
  assign w_if_tag    = if_pc[XLEN-1:c_IDX+2];
  assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = pred_hit && r_ctr[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + c_PC_STEP);

  assign w_ex_idx    = ex_pc[c_IDX+1:2];
  assign w_ex_tag    = ex_pc[XLEN-1:c_IDX+2];
  assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_ctr    = r_ctr[w_ex_idx];

  // Branch condition evaluation; funct3 010/011 are not branch encodings
  always_comb begin
    w_cond       = 1'b0;
    w_cond_known = 1'b1;
    case (ex_funct3)
      3'b000:  w_cond = (ex_op1 == ex_op2);
      3'b001:  w_cond = (ex_op1 != ex_op2);
      3'b100:  w_cond = ($signed(ex_op1) <  $signed(ex_op2));
      3'b101:  w_cond = ($signed(ex_op1) >= $signed(ex_op2));
      3'b110:  w_cond = (ex_op1 <  ex_op2);
      3'b111:  w_cond = (ex_op1 >= ex_op2);
      default: w_cond_known = 1'b0;
    endcase
  end

  assign ex_taken     = ex_jump ? 1'b1 : (ex_branch ? w_cond : 1'b0);
  assign w_resolve    = ex_valid && (ex_branch || ex_jump);
  assign w_correct_pc = ex_taken ? ex_target : (ex_pc + c_PC_STEP);

  // Only real branches/jumps train the table; a not-taken miss allocates nothing
  assign w_tbl_wr = w_resolve && !rst && (ex_jump || w_cond_known) &&
                    (w_ex_hit || ex_taken);

  // New counter value: jumps pin strongly-taken, fresh branches start weakly-taken
  always_comb begin
    w_ctr_new = w_ex_ctr;
    if (ex_jump) begin
      w_ctr_new = c_CTR_MAX;
    end else if (!w_ex_hit) begin
      w_ctr_new = c_CTR_NEW;
    end else if (ex_taken) begin
      if (w_ex_ctr != c_CTR_MAX) w_ctr_new = w_ex_ctr + 2'd1;
    end else begin
      if (w_ex_ctr != 2'b00) w_ctr_new = w_ex_ctr - 2'd1;
    end
  end

  // A non-control instruction predicted taken means an aliased BTB entry
  always_comb begin
    w_mispred = 1'b0;
    if (ex_valid) begin
      if (w_resolve) begin
        w_mispred = (ex_taken != ex_pred_taken) ||
                    (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
      end else begin
        w_mispred = ex_pred_taken;
      end
    end
  end

  // Valid bits and counters: reset, then trained on resolve events
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= c_CTR_RST;
      end
    end else if (w_tbl_wr) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_ctr[w_ex_idx]   <= w_ctr_new;
    end
  end

  // Tag and target capture on taken writes (hit refresh or allocation)
  always_ff @(posedge clk) begin
    if (w_tbl_wr && ex_taken) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= ex_target;
    end
  end

  // Registered redirect pulse and wrapping event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_resolved    <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_mispredict <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_correct_pc;
      if (w_resolve) r_resolved    <= r_resolved + 32'd1;
      if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign mispredict       = r_mispredict;
  assign redirect_pc      = r_redirect_pc;
  assign resolved_count   = r_resolved;
  assign mispredict_count = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Directed scoreboard bench for branch_predict_unit. The driver
//            queues hand-computed expectations tagged with the cycle they
//            are due; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int c_K_HIT = 0;
  localparam int c_K_TKN = 1;
  localparam int c_K_TGT = 2;
  localparam int c_K_EXT = 3;
  localparam int c_K_MP  = 4;
  localparam int c_K_RPC = 5;
  localparam int c_K_RES = 6;
  localparam int c_K_MPC = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_branch, ex_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_op1, ex_op2, ex_pc, ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc, resolved_count, mispredict_count;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .resolved_count(resolved_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int k);
    case (k)
      c_K_HIT: return {31'd0, pred_hit};
      c_K_TKN: return {31'd0, pred_taken};
      c_K_TGT: return pred_target;
      c_K_EXT: return {31'd0, ex_taken};
      c_K_MP:  return {31'd0, mispredict};
      c_K_RPC: return redirect_pc;
      c_K_RES: return resolved_count;
      default: return mispredict_count;
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due this cycle
  always @(negedge clk) begin
    int i;
    logic [31:0] a;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].due <= cyc) begin
        n_vec++;
        a = actual(sbq[i].kind);
        if (sbq[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed its cycle %0d (now %0d)", sbq[i].name, sbq[i].due, cyc);
        end else if (a !== sbq[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", sbq[i].name, a, sbq[i].exp, cyc);
        end
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] exp, input int dly, input string name);
    chk_t c;
    c.due  = cyc + dly;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sbq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_funct3 = 3'b000;
    ex_op1 = '0; ex_op2 = '0; ex_pc = '0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0; ex_funct3 = f3;
    ex_op1 = a; ex_op2 = b; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic cond_only(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    idle_ex();
    ex_branch = 1'b1; ex_funct3 = f3; ex_op1 = a; ex_op2 = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_pc = '0; idle_ex();
    step(); step();

    // reset state and cold lookup
    rst = 1'b0; if_pc = 32'h100;
    expect_v(c_K_HIT, 0, 0, "reset_hit");
    expect_v(c_K_TKN, 0, 0, "reset_taken");
    expect_v(c_K_TGT, 32'h104, 0, "reset_target");
    expect_v(c_K_RES, 0, 0, "reset_resolved");
    expect_v(c_K_MPC, 0, 0, "reset_mpcount");
    expect_v(c_K_MP,  0, 0, "reset_mispredict");
    expect_v(c_K_RPC, 0, 0, "reset_redirect");
    step();

    // BEQ taken, predicted not taken
    br(32'h100, 3'b000, 5, 5, 32'h80, 1'b0, 32'h104);
    expect_v(c_K_EXT, 1, 0, "beq_ex_taken");
    expect_v(c_K_HIT, 0, 0, "beq_same_cycle_hit");
    expect_v(c_K_MP,  1, 1, "beq_mispredict");
    expect_v(c_K_RPC, 32'h80, 1, "beq_redirect");
    expect_v(c_K_MPC, 1, 1, "beq_mpcount");
    expect_v(c_K_RES, 1, 1, "beq_resolved");
    step();

    idle_ex();
    expect_v(c_K_HIT, 1, 0, "alloc_hit");
    expect_v(c_K_TKN, 1, 0, "alloc_taken");
    expect_v(c_K_TGT, 32'h80, 0, "alloc_target");
    expect_v(c_K_MP,  0, 1, "pulse_one_cycle");
    expect_v(c_K_RPC, 32'h80, 1, "redirect_holds");
    step();

    // condition decode only (ex_valid low: no training, no mispredict)
    cond_only(3'b100, 32'hFFFF_FFFF, 1); expect_v(c_K_EXT, 1, 0, "blt_signed");  step();
    cond_only(3'b110, 32'hFFFF_FFFF, 1); expect_v(c_K_EXT, 0, 0, "bltu");        step();
    cond_only(3'b111, 0, 0);             expect_v(c_K_EXT, 1, 0, "bgeu_eq");     step();
    cond_only(3'b101, 32'hFFFF_FFFF, 1); expect_v(c_K_EXT, 0, 0, "bge_signed");  step();
    cond_only(3'b001, 5, 5);             expect_v(c_K_EXT, 0, 0, "bne_eq");      step();
    cond_only(3'b011, 0, 0);             expect_v(c_K_EXT, 0, 0, "f3_011");
    expect_v(c_K_MP, 0, 1, "novalid_no_mp");
    step();

    // train pc 0x200: miss-alloc (10), 11, 11, then two not-taken
    if_pc = 32'h200;
    br(32'h200, 3'b000, 7, 7, 32'h240, 1'b0, 32'h204);
    expect_v(c_K_HIT, 0, 0, "t1_hit");
    expect_v(c_K_MP,  1, 1, "t1_mp");
    expect_v(c_K_RPC, 32'h240, 1, "t1_redirect");
    step();
    br(32'h200, 3'b000, 7, 7, 32'h240, 1'b1, 32'h240);
    expect_v(c_K_HIT, 1, 0, "t2_hit");
    expect_v(c_K_TKN, 1, 0, "t2_taken");
    expect_v(c_K_TGT, 32'h240, 0, "t2_target");
    expect_v(c_K_MP,  0, 1, "t2_no_mp");
    step();
    expect_v(c_K_MP,  0, 1, "t3_no_mp");
    step();
    br(32'h200, 3'b000, 1, 2, 32'h240, 1'b1, 32'h240);
    expect_v(c_K_EXT, 0, 0, "t4_ex_taken");
    expect_v(c_K_MP,  1, 1, "t4_mp");
    expect_v(c_K_RPC, 32'h204, 1, "t4_redirect");
    step();
    expect_v(c_K_TKN, 1, 0, "ctr10_taken");
    expect_v(c_K_TGT, 32'h240, 0, "ctr10_target");
    expect_v(c_K_MP,  1, 1, "t5_b2b_mp");
    expect_v(c_K_RPC, 32'h204, 1, "t5_redirect");
    step();
    idle_ex();
    expect_v(c_K_HIT, 1, 0, "ctr01_hit");
    expect_v(c_K_TKN, 0, 0, "ctr01_taken");
    expect_v(c_K_TGT, 32'h204, 0, "ctr01_target");
    expect_v(c_K_RES, 6, 0, "train_resolved");
    expect_v(c_K_MPC, 4, 0, "train_mpcount");
    expect_v(c_K_MP,  0, 1, "train_pulse_end");
    step();

    // not-taken miss at 0x300 must not allocate
    if_pc = 32'h300;
    br(32'h300, 3'b000, 1, 2, 32'h340, 1'b0, 32'h304);
    expect_v(c_K_HIT, 0, 0, "nt_miss_hit");
    expect_v(c_K_MP,  0, 1, "nt_miss_no_mp");
    step();
    idle_ex();
    expect_v(c_K_HIT, 0, 0, "nt_no_alloc");
    expect_v(c_K_TGT, 32'h304, 0, "nt_target");
    expect_v(c_K_RES, 7, 0, "nt_resolved");
    step();

    // JAL with wrong predicted target
    if_pc = 32'h40;
    idle_ex();
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'h40; ex_target = 32'h600;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h500;
    expect_v(c_K_EXT, 1, 0, "jal_ex_taken");
    expect_v(c_K_MP,  1, 1, "jal_mp");
    expect_v(c_K_RPC, 32'h600, 1, "jal_redirect");
    step();

    // aliased non-control instruction at top of address space
    idle_ex();
    ex_valid = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_target = 32'h1234;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h1234;
    expect_v(c_K_HIT, 1, 0, "jal_alloc_hit");
    expect_v(c_K_TKN, 1, 0, "jal_alloc_taken");
    expect_v(c_K_TGT, 32'h600, 0, "jal_alloc_target");
    expect_v(c_K_EXT, 0, 0, "alias_ex_taken");
    expect_v(c_K_MP,  1, 1, "alias_mp");
    expect_v(c_K_RPC, 32'h0, 1, "alias_wrap");
    step();

    // funct3 010 twice on the hit entry: resolved, mispredicted, never trained
    br(32'h40, 3'b010, 3, 3, 32'h700, 1'b1, 32'h600);
    expect_v(c_K_EXT, 0, 0, "f3_010_ex_taken");
    expect_v(c_K_MP,  1, 1, "f3_010_mp1");
    expect_v(c_K_RPC, 32'h44, 1, "f3_010_redirect1");
    step();
    expect_v(c_K_MP,  1, 1, "f3_010_mp2");
    expect_v(c_K_RPC, 32'h44, 1, "f3_010_redirect2");
    step();
    idle_ex();
    expect_v(c_K_TKN, 1, 0, "f3_010_no_train");
    expect_v(c_K_TGT, 32'h600, 0, "alias_no_write");
    expect_v(c_K_RES, 10, 0, "final_resolved");
    expect_v(c_K_MPC, 8, 0, "final_mpcount");
    expect_v(c_K_MP,  0, 1, "final_pulse_end");
    step();

    // misprediction alongside reset
    rst = 1'b1;
    br(32'h700, 3'b000, 1, 1, 32'h900, 1'b0, 32'h704);
    step();
    rst = 1'b0; idle_ex(); if_pc = 32'h700;
    expect_v(c_K_HIT, 0, 0, "rst_no_alloc");
    expect_v(c_K_MP,  0, 0, "rst_mp_suppressed");
    expect_v(c_K_RPC, 0, 0, "rst_redirect");
    expect_v(c_K_RES, 0, 0, "rst_resolved");
    expect_v(c_K_MPC, 0, 0, "rst_mpcount");
    step();
    if_pc = 32'h40;
    expect_v(c_K_HIT, 0, 0, "rst_valid_cleared");
    step();
    step();
    step();

    while (sbq.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: expectation never checked (due %0d)", sbq[0].name, sbq[0].due);
      sbq.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
